// File: rtl/inst_prefetch_queue.sv
// In-order instruction prefetch queue between the bridge's SRAM-like fetch port
// and the IF stage; a redirect drops buffered words and cancels in-flight ones.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);
    localparam logic [PTR_W:0]   DEPTH_P = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_S = (PTR_W+2)'(DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);

    logic [31:0]      fetch_pc;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W:0]   head;
    logic [PTR_W:0]   fill;
    logic [PTR_W:0]   tail;
    logic [PTR_W:0]   cancel_cnt;
    logic [PTR_W:0]   occ;
    logic [PTR_W:0]   live;
    logic [PTR_W+1:0] pending;
    logic             issue;
    logic             fill_en;
    logic             pop;

    assign occ     = tail - head;
    assign live    = tail - fill;
    // Every outstanding bridge read, cancelled or not, occupies a response slot.
    assign pending = {1'b0, cancel_cnt} + {1'b0, live};

    assign inst_sram_req   = !reset && !flush && (occ < DEPTH_P) && (pending < DEPTH_S);
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = 32'd0;

    assign issue   = inst_sram_req && inst_sram_addr_ok;
    assign fill_en = !reset && !flush && inst_sram_data_ok && (cancel_cnt == '0);
    assign pop     = out_valid && out_ready && !flush;

    assign out_valid = (fill != head);
    assign out_pc    = pc_mem[head[PTR_W-1:0]];
    assign out_inst  = inst_mem[head[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            head       <= '0;
            fill       <= '0;
            tail       <= '0;
            cancel_cnt <= '0;
        end else if (flush) begin
            head       <= tail;
            fill       <= tail;
            fetch_pc   <= flush_pc & 32'hffff_fffc;
            // A word returning in the flush cycle is old-stream and retires one cancel.
            cancel_cnt <= cancel_cnt + live - {{PTR_W{1'b0}}, inst_sram_data_ok};
        end else begin
            if (issue) begin
                tail     <= tail + PTR_ONE;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (inst_sram_data_ok) begin
                if (cancel_cnt != '0) begin
                    cancel_cnt <= cancel_cnt - PTR_ONE;
                end else begin
                    fill <= fill + PTR_ONE;
                end
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_mem[tail[PTR_W-1:0]] <= fetch_pc;
        end
        if (fill_en) begin
            inst_mem[fill[PTR_W-1:0]] <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: bridge model with in-order responses and a
// scoreboard of expected {pc, inst} pairs pushed at issue, popped at IF accept.
module tb_inst_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    inst_prefetch_queue #(.DEPTH(DEPTH), .PTR_W(2), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .flush_pc(flush_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .inst_sram_req(inst_sram_req),
        .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fpc;
        logic [31:0] a0;
        logic [31:0] a1;
        bit          dok;
        int          n_issue;
    } flush_vec_t;

    flush_vec_t  fv [4];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    int          n_pops   = 0;
    int          ao_pct, do_pct, ready_pct, lat;
    bit          rst_next, flush_next, after_reset, after_flush;
    logic [31:0] flush_target;
    logic [31:0] exp_fetch;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] exp_pc    [$];
    logic        s_req, s_valid, s_popped;
    logic [31:0] s_addr, s_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'hc3c3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, observe handshakes 1ns later.
    task automatic cycle();
        logic [31:0] p;
        @(negedge clk);
        cyc++;
        reset      = rst_next;
        rst_next   = 1'b0;
        flush      = flush_next;
        flush_pc   = flush_target;
        flush_next = 1'b0;
        out_ready         = ($urandom_range(99) < ready_pct);
        inst_sram_addr_ok = ($urandom_range(99) < ao_pct);
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;
        if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc && $urandom_range(99) < do_pct) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem_word(pend_addr[0]);
        end
        #1;
        s_req    = inst_sram_req;
        s_addr   = inst_sram_addr;
        s_valid  = out_valid;
        s_popped = 1'b0;
        if (reset) begin
            check("req_in_reset", inst_sram_req, 0);
            pend_addr.delete();
            pend_due.delete();
            exp_pc.delete();
            exp_fetch   = RESET_PC;
            after_reset = 1'b1;
            after_flush = 1'b0;
        end else begin
            if (after_reset) begin
                check("valid_after_reset", out_valid, 0);
                if (!flush) begin
                    check("req_after_reset", inst_sram_req, 1);
                    check("addr_after_reset", inst_sram_addr, RESET_PC);
                end
            end
            if (after_flush) check("valid_after_flush", out_valid, 0);
            if (flush) check("req_during_flush", inst_sram_req, 0);
            if (inst_sram_req && inst_sram_addr_ok) begin
                check("fetch_addr", inst_sram_addr, exp_fetch);
                pend_addr.push_back(exp_fetch);
                pend_due.push_back(cyc + lat);
                exp_pc.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                n_acc++;
            end
            if (inst_sram_data_ok) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (flush) begin
                exp_pc.delete();
                exp_fetch = flush_pc & 32'hffff_fffc;
            end else if (out_valid && out_ready) begin
                s_popped = 1'b1;
                s_pop_pc = out_pc;
                n_pops++;
                if (exp_pc.size() == 0) begin
                    check("pop_unexpected", out_pc, 32'hxxxxxxxx);
                end else begin
                    p = exp_pc.pop_front();
                    check("out_pc", out_pc, p);
                    check("out_inst", out_inst, mem_word(p));
                end
            end
            check("occ_bound", exp_pc.size() <= DEPTH, 1);
            check("inflight_bound", pend_addr.size() <= DEPTH, 1);
            after_reset = 1'b0;
            after_flush = flush;
        end
    endtask

    task automatic do_reset();
        rst_next = 1'b1;
        cycle();
    endtask

    initial begin
        int          a0, p0, first_pop;
        bit          got;
        logic [31:0] fp;

        fv[0] = '{32'h1c000202, 32'h1c000200, 32'h1c000204, 1'b1, 4};
        fv[1] = '{32'h1c000103, 32'h1c000100, 32'h1c000104, 1'b0, 3};
        fv[2] = '{32'hfffffffc, 32'hfffffffc, 32'h00000000, 1'b0, 3};
        fv[3] = '{32'h00000001, 32'h00000000, 32'h00000004, 1'b1, 4};

        reset = 1'b1; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        rst_next = 1'b0; flush_next = 1'b0; flush_target = '0;
        after_reset = 1'b0; after_flush = 1'b0; exp_fetch = RESET_PC;
        ao_pct = 100; do_pct = 100; ready_pct = 100; lat = 1;

        do_reset();
        do_reset();
        check("const_wr", inst_sram_wr, 0);
        check("const_size", inst_sram_size, 2);
        check("const_wstrb", inst_sram_wstrb, 0);
        check("const_wdata", inst_sram_wdata, 0);

        // Streaming: 1-cycle latency, IF always ready.
        first_pop = 0;
        p0 = n_pops;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (s_popped && first_pop == 0) first_pop = i;
        end
        check("first_out_cycle", first_pop, 3);
        check("stream_pops", n_pops - p0, 10);

        // Fill to DEPTH with IF stalled, then drain.
        do_reset();
        ready_pct = 0; lat = 3; a0 = n_acc;
        repeat (12) cycle();
        check("full_issue_count", n_acc - a0, DEPTH);
        check("req_when_full", s_req, 0);
        ready_pct = 100;
        cycle();
        check("pop_when_full", s_valid, 1);
        check("no_issue_on_full_pop", s_req, 0);
        cycle();
        check("issue_resumes", s_req, 1);
        repeat (10) cycle();

        // Redirect with 3 fetches in flight and 1 buffered.
        do_reset();
        ready_pct = 0; ao_pct = 100; do_pct = 0; lat = 1;
        repeat (4) cycle();
        ao_pct = 0; do_pct = 100;
        cycle();
        do_pct = 0; ao_pct = 100; flush_next = 1'b1; flush_target = 32'h1c000100;
        cycle();
        a0 = n_acc;
        repeat (4) cycle();
        check("issue_limited_by_cancel", n_acc - a0, 1);
        do_pct = 100; ready_pct = 100; got = 1'b0; fp = 32'hdeadbeef;
        repeat (12) begin
            cycle();
            if (s_popped && !got) begin got = 1'b1; fp = s_pop_pc; end
        end
        check("first_pc_after_flush", fp, 32'h1c000100);

        // Table of redirects, with and without a data_ok in the flush cycle.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            ready_pct = 100; lat = 1; do_pct = 0; ao_pct = 100;
            cycle();
            ao_pct = 0; do_pct = fv[k].dok ? 100 : 0;
            flush_next = 1'b1; flush_target = fv[k].fpc;
            cycle();
            do_pct = 0; ao_pct = 100; a0 = n_acc;
            cycle();
            check("flush_req", s_req, 1);
            check("flush_addr0", s_addr, fv[k].a0);
            cycle();
            check("flush_addr1", s_addr, fv[k].a1);
            repeat (3) cycle();
            check("flush_issue_count", n_acc - a0, fv[k].n_issue);
            do_pct = 100; got = 1'b0; fp = 32'hdeadbeef;
            repeat (10) begin
                cycle();
                if (s_popped && !got) begin got = 1'b1; fp = s_pop_pc; end
            end
            check("flush_first_pc", fp, fv[k].a0);
        end

        // Random stalls and periodic redirects.
        do_reset();
        ao_pct = 60; do_pct = 60; ready_pct = 70;
        p0 = n_pops;
        for (int i = 0; i < 10000; i++) begin
            lat = int'($urandom_range(1, 4));
            if ($urandom_range(19) == 0) begin
                flush_next   = 1'b1;
                flush_target = $urandom;
            end
            cycle();
        end
        check("random_pops", (n_pops - p0) > 1000, 1);

        // Reset while full.
        do_reset();
        ao_pct = 100; do_pct = 100; lat = 1; ready_pct = 0;
        repeat (8) cycle();
        check("full_before_reset", s_valid, 1);
        check("full_req_low", s_req, 0);
        do_reset();
        ready_pct = 100;
        cycle();
        check("addr_after_full_reset", s_addr, RESET_PC);
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
